// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: FSM state encodings and the
// maximum master count the 3-bit owner index can address.
package bus_rr_arbiter_pkg;

  localparam int BUS_N_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request after 'last' (with
// wrap-around) wins, or the lowest set request when 'fixed' is high.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  input  logic         fixed,
  output logic         any,
  output logic [2:0]   idx,
  output logic [N-1:0] onehot
);

  logic [2:0] cand;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      if (fixed) cand = 3'(i);
      else       cand = 3'((int'(last) + 1 + i) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin system-bus arbiter with a BUS_ready watchdog. A hung owner is revoked,
// flagged on bus_err and kept out of arbitration until it withdraws its request.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8,
  parameter bit FIXED   = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] DMA,
  input  logic         BUS_ready,
  output logic [N-1:0] grant,
  output logic         BUS_req,
  output logic [2:0]   owner,
  output logic         bus_err
);

  // state   | meaning
  // IDLE    | no owner, arbitrate among eligible requests
  // OWNED   | grant held while owner requests, watchdog running
  // RELEASE | single grant=0 turnaround cycle after an owner leaves or is revoked

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  blocked_q, blocked_d;
  logic [2:0]    owner_q, owner_d;
  logic [2:0]    last_q, last_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_err_q, bus_err_d;

  logic [N-1:0]  eligible, pick_onehot;
  logic [2:0]    pick_idx;
  logic          pick_any, owner_req;

  assign eligible  = DMA & ~blocked_q;
  assign owner_req = DMA[owner_q];

  rr_pick #(.N(N)) u_pick (
    .req    (eligible),
    .last   (last_q),
    .fixed  (FIXED),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    bus_err_d = 1'b0;
    blocked_d = blocked_q & DMA;

    case (state_q)
      // The turnaround cycle doubles as an arbitration slot, so the next owner
      // follows a single grant=0 cycle.
      ST_IDLE, ST_RELEASE: begin
        state_d = ST_IDLE;
        if (pick_any) begin
          state_d = ST_OWNED;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          last_d  = pick_idx;
          wdog_d  = '0;
        end
      end
      ST_OWNED: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (BUS_ready) begin
          wdog_d = '0;
        end else if (wdog_q == TW'(TIMEOUT)) begin
          grant_d   = '0;
          bus_err_d = 1'b1;
          blocked_d = blocked_d | grant_q;
          state_d   = ST_RELEASE;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    bus_req_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= 3'(N - 1);
      wdog_q    <= '0;
      blocked_q <= '0;
      bus_req_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      blocked_q <= blocked_d;
      bus_req_q <= bus_req_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign grant   = grant_q;
  assign BUS_req = bus_req_q;
  assign owner   = owner_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of ownership, watchdog and blocking.
module tb_bus_rr_arbiter;

  localparam int N  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] dma = '0;
  logic         rdy = 1'b0;
  logic [N-1:0] grant;
  logic         bus_req;
  logic [2:0]   owner;
  logic         bus_err;

  int n_chk  = 0;
  int n_pass = 0;

  // model: current owner (-1 = none), owner output, RR pointer, ready-less cycles
  int m_own   = -1;
  int m_out   = 0;
  int m_last  = N - 1;
  int m_quiet = 0;
  bit m_err   = 1'b0;
  bit m_blk [N];

  bus_rr_arbiter #(.N(N), .TIMEOUT(TO), .TW(8), .FIXED(1'b0)) dut (
    .clk       (clk),
    .clr       (clr),
    .DMA       (dma),
    .BUS_ready (rdy),
    .grant     (grant),
    .BUS_req   (bus_req),
    .owner     (owner),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_edge();
    bit old_blk [N];
    int k;
    if (!clr) begin
      m_own = -1; m_out = 0; m_last = N - 1; m_quiet = 0; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
      return;
    end
    old_blk = m_blk;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) m_blk[i] = old_blk[i] && dma[i];
    if (m_own >= 0) begin
      if (!dma[m_own]) m_own = -1;
      else if (rdy) m_quiet = 0;
      else if (m_quiet == TO) begin
        m_err = 1'b1;
        m_blk[m_own] = 1'b1;
        m_own = -1;
      end else m_quiet++;
    end else begin
      for (int j = 1; j <= N; j++) begin
        k = (m_last + j) % N;
        if (dma[k] && !old_blk[k]) begin
          m_own = k; m_out = k; m_last = k; m_quiet = 0;
          break;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".grant"},   32'(grant),   32'(exp_grant()));
    chk({tag, ".bus_req"}, 32'(bus_req), 32'(m_own >= 0));
    chk({tag, ".owner"},   32'(owner),   32'(m_out));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_err));
  endtask

  task automatic step(input logic c, input logic [N-1:0] d, input logic r, input string tag);
    clr = c; dma = d; rdy = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] rd;
    int cyc;

    // 1: reset with all requests high, then first grant to master 0
    step(1'b0, 8'hFF, 1'b0, "t1_rst");
    step(1'b0, 8'hFF, 1'b0, "t1_rst");
    chk("t1_rst_grant", 32'(grant), 32'h0);
    step(1'b1, 8'h05, 1'b0, "t1_first");
    chk("t1_first_grant", 32'(grant), 32'h01);

    // 2: masters 0 and 2 alternate, one zero cycle between owners
    for (int r = 0; r < 4; r++) begin
      g = grant;
      chk("t2_alt", 32'(g), (r % 2 == 0) ? 32'h01 : 32'h04);
      step(1'b1, 8'h05, 1'b0, "t2");
      step(1'b1, 8'h05, 1'b0, "t2");
      step(1'b1, 8'h05 & ~g, 1'b0, "t2_drop");
      chk("t2_gap", 32'(grant), 32'h0);
      step(1'b1, 8'h05, 1'b0, "t2_next");
    end

    // 3: owner 2 keeps the bus for 10 cycles despite master 0 waiting
    step(1'b1, 8'h04, 1'b0, "t3_drop0");
    step(1'b1, 8'h05, 1'b0, "t3_grant2");
    chk("t3_hold", 32'(grant), 32'h04);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'h05, 1'(i % 2), "t3");
      chk("t3_hold", 32'(grant), 32'h04);
    end
    step(1'b1, 8'h01, 1'b0, "t3_drop2");
    chk("t3_gap", 32'(grant), 32'h0);
    step(1'b1, 8'h01, 1'b0, "t3_grant0");
    chk("t3_after", 32'(grant), 32'h01);

    // 4: watchdog revokes master 1, master 3 served, 1 needs to re-request
    step(1'b0, 8'h0A, 1'b0, "t4_rst");
    step(1'b1, 8'h0A, 1'b0, "t4_grant1");
    chk("t4_grant1", 32'(grant), 32'h02);
    cyc = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h0A, 1'b0, "t4_wait");
      cyc++;
      if (bus_err) break;
    end
    chk("t4_err_cycle", 32'(cyc), 32'd6);
    chk("t4_err_grant", 32'(grant), 32'h0);
    step(1'b1, 8'h0A, 1'b0, "t4_grant3");
    chk("t4_grant3", 32'(grant), 32'h08);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h0A, 1'b1, "t4_own3");
    step(1'b1, 8'h02, 1'b0, "t4_drop3");
    step(1'b1, 8'h02, 1'b0, "t4_blocked");
    chk("t4_blocked", 32'(grant), 32'h0);
    step(1'b1, 8'h00, 1'b0, "t4_withdraw");
    step(1'b1, 8'h02, 1'b0, "t4_rereq");
    chk("t4_rereq", 32'(grant), 32'h02);

    // 5: BUS_ready every third cycle keeps the watchdog quiet
    step(1'b0, 8'h01, 1'b0, "t5_rst");
    step(1'b1, 8'h01, 1'b0, "t5_grant");
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 8'h01, 1'(i % 3 == 2), "t5");
      chk("t5_no_err", 32'(bus_err), 32'h0);
    end
    chk("t5_still_owned", 32'(grant), 32'h01);

    // 6: reset mid-ownership, then master 7 alone
    step(1'b0, 8'h01, 1'b0, "t6_rst");
    chk("t6_rst_grant", 32'(grant), 32'h0);
    step(1'b1, 8'h80, 1'b0, "t6_grant7");
    chk("t6_grant7", 32'(grant), 32'h80);
    chk("t6_owner7", 32'(owner), 32'd7);

    // random traffic: requests toggle occasionally, sparse BUS_ready, rare reset
    rd = 8'h80;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) rd[k] = ~rd[k];
      step(1'($urandom_range(0, 199) != 0), rd, 1'($urandom_range(0, 9) < 4), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
